// File: rtl/mrf_nwnr_bypass.sv
// N-write/N-read register file with registered reads, same-cycle write bypass,
// highest-port-wins write merging, optional hard-zero entry 0 and a clear sequencer.
module mrf_nwnr_bypass #(
  parameter int              DW        = 64,
  parameter int              AW        = 5,
  parameter int              NUM_READ  = 4,
  parameter int              NUM_WRITE = 2,
  parameter int              ZERO_REG  = 1,
  parameter logic [DW-1:0]   INIT_VAL  = {DW{1'b0}}
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  output logic                     READY,
  input  logic [NUM_READ-1:0]      RE,
  input  logic [NUM_READ*AW-1:0]   RADDR,
  output logic [NUM_READ*DW-1:0]   RDATA,
  input  logic [NUM_WRITE-1:0]     WE,
  input  logic [NUM_WRITE*AW-1:0]  WADDR,
  input  logic [NUM_WRITE*DW-1:0]  WDATA
);

  localparam int       DEPTH   = 1 << AW;
  localparam logic     ZR      = (ZERO_REG != 32'sd0);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_r, state_nxt_s;
  logic [AW-1:0] cnt_r, cnt_nxt_s;
  logic          ready_r;
  logic [DW-1:0] mem_r       [DEPTH];
  logic [DW-1:0] rdata_r     [NUM_READ];
  logic [DW-1:0] rdata_nxt_s [NUM_READ];
  logic [AW-1:0] raddr_s     [NUM_READ];
  logic [AW-1:0] waddr_s     [NUM_WRITE];
  logic [DW-1:0] wdata_s     [NUM_WRITE];
  logic [NUM_WRITE-1:0] we_eff_s;

  // Clear sequencer next-state: walk every entry once, then go live.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_nxt_s = cnt_r + AW'(1'b1);
        if (cnt_r == {AW{1'b1}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        cnt_nxt_s   = {AW{1'b0}};
        state_nxt_s = ST_RUN;
      end
      default: begin
        cnt_nxt_s   = {AW{1'b0}};
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Sequencer state, counter and READY flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_INIT;
      cnt_r   <= {AW{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Unpack ports and qualify writes; entry 0 writes vanish when it is hard-wired.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      raddr_s[i] = RADDR[i*AW +: AW];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      waddr_s[j]  = WADDR[j*AW +: AW];
      wdata_s[j]  = WDATA[j*DW +: DW];
      we_eff_s[j] = (state_r == ST_RUN) && WE[j] && !(ZR && (waddr_s[j] == {AW{1'b0}}));
    end
  end

  // Storage: later ports are applied last, so the highest index wins a collision.
  always_ff @(posedge CLK) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= INIT_VAL;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (we_eff_s[j]) begin
          mem_r[waddr_s[j]] <= wdata_s[j];
        end
      end
    end
  end

  // Read mux with bypass from the winning same-cycle write.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rdata_nxt_s[i] = rdata_r[i];
      if (state_r != ST_RUN) begin
        rdata_nxt_s[i] = {DW{1'b0}};
      end else if (!RE[i]) begin
        rdata_nxt_s[i] = rdata_r[i];
      end else if (ZR && (raddr_s[i] == {AW{1'b0}})) begin
        rdata_nxt_s[i] = {DW{1'b0}};
      end else begin
        rdata_nxt_s[i] = mem_r[raddr_s[i]];
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (we_eff_s[j] && (waddr_s[j] == raddr_s[i])) begin
            rdata_nxt_s[i] = wdata_s[j];
          end else begin
            rdata_nxt_s[i] = rdata_nxt_s[i];
          end
        end
      end
    end
  end

  // Registered read data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_READ; i++) begin
        rdata_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_READ; i++) begin
        rdata_r[i] <= rdata_nxt_s[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rdata
    assign RDATA[g*DW +: DW] = rdata_r[g];
  end

  assign READY = ready_r;

endmodule
